// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard receiver with make/break decoding and a held-key bitmap.
// Each tracked key comes from a packed scan-code map; changes raise a pulse.
module ps2_key_tracker #(
  parameter int NUM_KEYS = 5,
  parameter logic [9*NUM_KEYS-1:0] KEYMAP =
    {9'h029, 9'h174, 9'h172, 9'h16B, 9'h175},
  parameter int TIMEOUT_CYCLES = 50000,
  localparam int EW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ps2_c,
  input  logic                ps2_d,
  output logic [NUM_KEYS-1:0] keys_pressed,
  output logic                key_event,
  output logic [EW-1:0]       event_index,
  output logic                event_make,
  output logic                frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} dec_t;

  logic          c_s1, c_s2, c_s3;
  logic          d_s1, d_s2;
  logic          strobe;
  logic [3:0]    bit_cnt;
  logic [10:0]   sr;
  logic [TW-1:0] wd;
  logic          done;
  dec_t          state;

  logic [7:0]    rx_byte;
  logic          frame_ok;
  logic          ext, brk;
  logic [8:0]    key;
  logic          hit;
  logic [EW-1:0] hit_idx;

  assign strobe   = c_s3 & ~c_s2;
  assign rx_byte  = sr[8:1];
  assign frame_ok = ~sr[0] & sr[10] & (^sr[9:1]);
  assign ext      = (state == EXT) || (state == EXT_BRK);
  assign brk      = (state == BRK) || (state == EXT_BRK);
  assign key      = {ext, rx_byte};

  // Scan from the top so the lowest matching index ends up selected.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (KEYMAP[9*i +: 9] == key) begin
        hit     = 1'b1;
        hit_idx = EW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_s1         <= 1'b1;
      c_s2         <= 1'b1;
      c_s3         <= 1'b1;
      d_s1         <= 1'b1;
      d_s2         <= 1'b1;
      bit_cnt      <= '0;
      sr           <= '0;
      wd           <= '0;
      done         <= 1'b0;
      state        <= IDLE;
      keys_pressed <= '0;
      key_event    <= 1'b0;
      event_index  <= '0;
      event_make   <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      c_s1      <= ps2_c;
      c_s2      <= c_s1;
      c_s3      <= c_s2;
      d_s1      <= ps2_d;
      d_s2      <= d_s1;
      done      <= 1'b0;
      key_event <= 1'b0;
      frame_err <= 1'b0;

      if (strobe) begin
        sr <= {d_s2, sr[10:1]};
        wd <= '0;
        if (bit_cnt == 4'd10) begin
          bit_cnt <= '0;
          done    <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (bit_cnt != '0) begin
        if (wd == TW'(TIMEOUT_CYCLES - 1)) begin
          bit_cnt   <= '0;
          wd        <= '0;
          frame_err <= 1'b1;
          state     <= IDLE;
        end else begin
          wd <= wd + 1'b1;
        end
      end else begin
        wd <= '0;
      end

      if (done) begin
        if (!frame_ok) begin
          frame_err <= 1'b1;
          state     <= IDLE;
        end else if (rx_byte == 8'hE0) begin
          state <= EXT;
        end else if (rx_byte == 8'hF0) begin
          unique case (state)
            IDLE:    state <= BRK;
            EXT:     state <= EXT_BRK;
            default: state <= state;
          endcase
        end else begin
          state <= IDLE;
          if (hit) begin
            keys_pressed[hit_idx] <= ~brk;
            // Repeats of a held key and releases of idle keys stay silent.
            if (keys_pressed[hit_idx] == brk) begin
              key_event   <= 1'b1;
              event_index <= hit_idx;
              event_make  <= ~brk;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker: frames, extended codes, errors, reset.
module tb_ps2_key_tracker;

  localparam int TO = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_c = 1'b1;
  logic       ps2_d = 1'b1;
  logic [4:0] keys;
  logic       key_event;
  logic [2:0] event_index;
  logic       event_make;
  logic       frame_err;
  logic [1:0] keys2;
  logic       key_event2;
  logic [0:0] event_index2;
  logic       event_make2;
  logic       frame_err2;

  int checks = 0;
  int errors = 0;
  int ev_cnt = 0;
  int fe_cnt = 0;
  int last_idx = 0;
  int last_make = 0;

  always #5 clk = ~clk;

  ps2_key_tracker #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .ps2_c(ps2_c), .ps2_d(ps2_d),
    .keys_pressed(keys), .key_event(key_event),
    .event_index(event_index), .event_make(event_make),
    .frame_err(frame_err)
  );

  ps2_key_tracker #(
    .NUM_KEYS(2), .KEYMAP({9'h01D, 9'h01D}), .TIMEOUT_CYCLES(TO)
  ) dut2 (
    .clk(clk), .rst(rst), .ps2_c(ps2_c), .ps2_d(ps2_d),
    .keys_pressed(keys2), .key_event(key_event2),
    .event_index(event_index2), .event_make(event_make2),
    .frame_err(frame_err2)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (key_event) begin
      ev_cnt++;
      last_idx  = int'(event_index);
      last_make = int'(event_make);
    end
    if (frame_err) fe_cnt++;
    if (key_event && frame_err)
      check("ev_fe_overlap", 1, 0);
  end

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_d = f[i];
      repeat (5) @(negedge clk);
      ps2_c = 1'b0;
      repeat (5) @(negedge clk);
      ps2_c = 1'b1;
    end
    repeat (20) @(negedge clk);
  endtask

  function automatic logic [10:0] frame(input logic [7:0] b,
                                        input logic bad);
    logic p;
    p = ~(^b) ^ bad;
    return {1'b1, p, b, 1'b0};
  endfunction

  task automatic send(input logic [7:0] b);
    send_bits(frame(b, 1'b0), 11);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_keys", 32'(keys), 0);
    check("rst_event", 32'(key_event), 0);
    check("rst_err", 32'(frame_err), 0);
    check("rst_idx", 32'(event_index), 0);
    check("rst_make", 32'(event_make), 0);

    send(8'h1D);
    check("unmapped_keys", 32'(keys), 0);
    check("unmapped_ev", ev_cnt, 0);
    check("dup_lowest", 32'(keys2), 32'h1);

    send(8'h29);
    check("space_keys", 32'(keys), 32'h10);
    check("space_ev", ev_cnt, 1);
    check("space_idx", last_idx, 4);
    check("space_make", last_make, 1);
    send(8'hF0); send(8'h29);
    check("space_rel_keys", 32'(keys), 0);
    check("space_rel_ev", ev_cnt, 2);
    check("space_rel_idx", last_idx, 4);
    check("space_rel_make", last_make, 0);

    send(8'hE0); send(8'h75);
    check("up_keys", 32'(keys), 32'h01);
    check("up_ev", ev_cnt, 3);
    check("up_idx", last_idx, 0);
    send(8'hE0); send(8'h75);
    check("up_repeat_ev", ev_cnt, 3);
    send(8'hE0); send(8'hF0); send(8'h75);
    check("up_rel_keys", 32'(keys), 0);
    check("up_rel_ev", ev_cnt, 4);
    check("up_rel_make", last_make, 0);
    send(8'h75);
    check("kp8_keys", 32'(keys), 0);
    check("kp8_ev", ev_cnt, 4);

    send_bits(frame(8'h1D, 1'b1), 11);
    check("parity_err", fe_cnt, 1);
    check("parity_keys", 32'(keys), 0);
    check("parity_keys2", 32'(keys2), 32'h1);
    send(8'hE0); send(8'h6B);
    check("left_keys", 32'(keys), 32'h02);
    check("left_ev", ev_cnt, 5);

    send_bits(frame(8'h29, 1'b0), 5);
    repeat (TO + 50) @(negedge clk);
    check("timeout_err", fe_cnt, 2);
    send(8'h29);
    check("after_to_keys", 32'(keys), 32'h12);
    check("after_to_ev", ev_cnt, 6);
    check("after_to_make", last_make, 1);

    send(8'hE0); send(8'h74);
    check("right_keys", 32'(keys), 32'h1A);
    send_bits(frame(8'hE0, 1'b0), 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (TO + 50) @(negedge clk);
    check("midrst_keys", 32'(keys), 0);
    check("midrst_err", fe_cnt, 2);
    send(8'hE0); send(8'h72);
    check("down_keys", 32'(keys), 32'h04);
    check("down_idx", last_idx, 2);
    check("final_err", fe_cnt, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ps2_key_tracker.md
PS2_KEY_TRACKER -- requirements
Module: ps2_key_tracker

Interface
REQ-001 Parameter NUM_KEYS, 5, number of tracked keys (1..32).
REQ-002 Parameter KEYMAP, {9'h029,9'h174,9'h172,9'h16B,9'h175}, NUM_KEYS packed 9-bit entries; entry i = KEYMAP[9i+8:9i]; bit 8 = E0-extended flag, bits 7:0 = scan code. Default: idx0 ext-Up, idx1 ext-Left, idx2 ext-Down, idx3 ext-Right, idx4 Space.
REQ-003 Parameter TIMEOUT_CYCLES, 50000, maximum clk cycles between PS/2 falling edges inside one frame.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 ps2_c  input  1  asynchronous PS/2 clock line.
REQ-007 ps2_d  input  1  asynchronous PS/2 data line.
REQ-008 keys_pressed  output  NUM_KEYS  bit i = 1 while key i held.
REQ-009 key_event  output  1  one-cycle pulse when any keys_pressed bit changes.
REQ-010 event_index  output  $clog2(NUM_KEYS) (min 1)  index of key that changed; valid with key_event.
REQ-011 event_make  output  1  1 = press, 0 = release; valid with key_event.
REQ-012 frame_err  output  1  one-cycle pulse on rejected frame.

Function
REQ-013 ps2_c and ps2_d shall each pass through a 2-FF synchroniser; sample strobe = synchronised ps2_c 1->0 transition; ps2_d sampled at that strobe.
REQ-014 Receiver shall collect 11 bits LSB-first: start, 8 data, odd parity, stop; bit counter 0..10, wraps to 0 after stop bit.
REQ-015 Frame accepted only if start=0, stop=1 and XOR of 8 data bits plus parity = 1; otherwise frame_err pulses, byte discarded, decoder FSM returns to IDLE.
REQ-016 Watchdog: if bit counter != 0 and TIMEOUT_CYCLES clk cycles elapse with no strobe, bit counter shall clear to 0, frame_err pulses, FSM returns to IDLE; counter restarts on every strobe.
REQ-017 Accepted byte processed in the cycle after the strobe that sampled stop bit; keys_pressed, key_event, event_index, event_make register on the following clk edge (2 clk after strobe).
REQ-018 Decoder FSM states IDLE, EXT, BRK, EXT_BRK; byte E0: any state -> EXT; byte F0: IDLE->BRK, EXT->EXT_BRK, BRK/EXT_BRK unchanged.
REQ-019 Any other byte: form key = {ext, byte}, ext = 1 in EXT/EXT_BRK; brk = 1 in BRK/EXT_BRK; FSM -> IDLE.
REQ-020 Lookup: lowest index i with KEYMAP entry == key matches; no match -> no output change, no event.
REQ-021 On match, keys_pressed[i] <= ~brk; key_event pulses only if bit value changes (typematic repeat of held key and release of non-held key produce no event).
REQ-022 Extended and non-extended codes are distinct: 75 (keypad 8) shall not match entry {1,75}.
REQ-023 frame_err and key_event are never asserted in the same cycle; event_index/event_make hold last values when key_event = 0.

Reset
REQ-024 rst shall clear: bit counter, shift register, watchdog, FSM (IDLE), keys_pressed (all 0), key_event, event_index, event_make, frame_err (0); synchroniser flops set to 1 (idle bus).
REQ-025 rst mid-frame shall abandon the partial frame with no frame_err; next start bit begins a fresh frame.

Verification
REQ-026 Frame 29 then F0 29 (default map) -> keys_pressed = 5'b10000 with key_event, idx 4, make 1; then 5'b00000 with key_event, idx 4, make 0.
REQ-027 E0 75, E0 75, E0 F0 75 -> one press event idx 0 then one release event idx 0; second make produces no key_event; plain 75 -> no change.
REQ-028 Frame 1D with parity bit inverted -> frame_err pulse, keys_pressed unchanged; following E0 6B -> keys_pressed[1] = 1.
REQ-029 Send 5 bits of a frame then hold ps2_c high TIMEOUT_CYCLES -> exactly one frame_err; subsequent full frame 29 decodes correctly.
REQ-030 E0 74 held, assert rst for 1 cycle mid-frame of next byte -> keys_pressed = 0, no frame_err; then E0 72 -> keys_pressed = 5'b00100.
REQ-031 Instance NUM_KEYS=2, KEYMAP={9'h01D,9'h01D} -> frame 1D sets only bit 0 (lowest index wins).
